// File: rtl/screen_draw_sequencer.sv
// Full-screen 160x120 scan sequencer: issues ROM addresses, delays pixel coordinates
// and the plot strobe to match the ROM/colour latency, and plays multi-frame runs.
module screen_draw_sequencer #(
  parameter int PIPE_LAT    = 2,
  parameter int HOLD_CYCLES = 12500000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [6:0]  image_sel,
  input  logic [2:0]  frame_count,
  input  logic        black_req,
  output logic [14:0] screen_addr,
  output logic [6:0]  memory_sel,
  output logic        black,
  output logic [7:0]  x,
  output logic [6:0]  y,
  output logic        plot,
  output logic        busy,
  output logic        done
);

  localparam logic [14:0] LAST_ADDR  = 15'd19199;
  localparam logic [7:0]  LAST_X     = 8'd159;
  localparam logic [1:0]  DRAIN_LAST = 2'(PIPE_LAT - 1);
  localparam logic [23:0] HOLD_LAST  = 24'(HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRAW,
    S_DRAIN,
    S_HOLD,
    S_DONE
  } state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] x;
    logic [6:0] y;
  } pix_t;

  state_e      state_q,   state_d;
  logic [14:0] addr_q,    addr_d;
  logic [7:0]  scan_x_q,  scan_x_d;
  logic [6:0]  scan_y_q,  scan_y_d;
  logic [6:0]  mem_sel_q, mem_sel_d;
  logic        black_q,   black_d;
  logic [2:0]  frames_q,  frames_d;
  logic [1:0]  drain_q,   drain_d;
  logic [23:0] hold_q,    hold_d;
  pix_t        pipe_q [PIPE_LAT];
  pix_t        pipe_d [PIPE_LAT];

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    state_d   = state_q;
    addr_d    = addr_q;
    scan_x_d  = scan_x_q;
    scan_y_d  = scan_y_q;
    mem_sel_d = mem_sel_q;
    black_d   = black_q;
    frames_d  = frames_q;
    drain_d   = drain_q;
    hold_d    = hold_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_DRAW;
          mem_sel_d = image_sel;
          frames_d  = (frame_count == 3'd0) ? 3'd1 : frame_count;
          black_d   = black_req;
          addr_d    = '0;
          scan_x_d  = '0;
          scan_y_d  = '0;
        end
      end
      S_DRAW: begin
        if (addr_q == LAST_ADDR) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 15'd1;
          if (scan_x_q == LAST_X) begin
            scan_x_d = '0;
            scan_y_d = scan_y_q + 7'd1;
          end else begin
            scan_x_d = scan_x_q + 8'd1;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (frames_q > 3'd1) begin
            state_d = S_HOLD;
            hold_d  = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end
      S_HOLD: begin
        if (hold_q == HOLD_LAST) begin
          state_d   = S_DRAW;
          frames_d  = frames_q - 3'd1;
          mem_sel_d = mem_sel_q + 7'd1;
          addr_d    = '0;
          scan_x_d  = '0;
          scan_y_d  = '0;
        end else begin
          hold_d = hold_q + 24'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Stage 0 samples the scan position of the address on the bus this cycle.
  always_comb begin
    pipe_d[0] = '{valid: (state_q == S_DRAW), x: scan_x_q, y: scan_y_q};
    for (int i = 1; i < PIPE_LAT; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: <= everywhere here so all flops update from pre-edge values.
      state_q   <= S_IDLE;
      addr_q    <= '0;
      scan_x_q  <= '0;
      scan_y_q  <= '0;
      mem_sel_q <= '0;
      black_q   <= 1'b0;
      frames_q  <= '0;
      drain_q   <= '0;
      hold_q    <= '0;
      // NOTE: the delay line is cleared on reset so no stale plot leaks out afterwards.
      pipe_q    <= '{default: '0};
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      scan_x_q  <= scan_x_d;
      scan_y_q  <= scan_y_d;
      mem_sel_q <= mem_sel_d;
      black_q   <= black_d;
      frames_q  <= frames_d;
      drain_q   <= drain_d;
      hold_q    <= hold_d;
      pipe_q    <= pipe_d;
    end
  end

  assign screen_addr = addr_q;
  assign memory_sel  = mem_sel_q;
  assign black       = black_q;
  assign plot        = pipe_q[PIPE_LAT-1].valid;
  assign x           = pipe_q[PIPE_LAT-1].x;
  assign y           = pipe_q[PIPE_LAT-1].y;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_screen_draw_sequencer.sv
// Bench for screen_draw_sequencer: a timing model derived from run start and frame period
// is compared every cycle, plus literal spot checks at known pixel/frame positions.
module tb_screen_draw_sequencer;

  localparam int PL   = 2;
  localparam int HC   = 4;
  localparam int NPIX = 19200;
  localparam int P    = NPIX + PL + HC;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic [6:0]  image_sel = '0;
  logic [2:0]  frame_count = '0;
  logic        black_req = 1'b0;
  logic [14:0] screen_addr;
  logic [6:0]  memory_sel;
  logic        black;
  logic [7:0]  x;
  logic [6:0]  y;
  logic        plot;
  logic        busy;
  logic        done;

  screen_draw_sequencer #(.PIPE_LAT(PL), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .resetn(resetn), .start(start), .image_sel(image_sel),
    .frame_count(frame_count), .black_req(black_req), .screen_addr(screen_addr),
    .memory_sel(memory_sel), .black(black), .x(x), .y(y), .plot(plot),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int plot_cnt = 0;
  int done_cnt = 0;
  bit jitter = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s actual=%0d expected=%0d edge=%0d", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: everything follows from the accepting edge k, the run length
  // and the frame period; t is the number of edges since acceptance.
  bit model_on = 1'b0, run_on = 1'b0, fresh = 1'b0, idle_prev, in_run;
  int k, nf, base, blk, t_done, t_cur, f_cur, o_cur, n_cur;

  always @(posedge clk) begin
    cyc++;
    if (!resetn) begin
      model_on = 1'b1;
      run_on   = 1'b0;
      fresh    = 1'b1;
    end else if (model_on) begin
      idle_prev = !run_on || ((cyc - 1 - k) > t_done);
      if (idle_prev && start) begin
        run_on = 1'b1;
        fresh  = 1'b0;
        k      = cyc;
        nf     = (frame_count == 3'd0) ? 1 : int'(frame_count);
        base   = int'(image_sel);
        blk    = int'(black_req);
        t_done = (nf - 1) * P + NPIX + PL;
      end
    end
    #1;
    if (model_on) begin
      t_cur  = cyc - k;
      in_run = run_on && (t_cur <= t_done);
      if (in_run) begin
        f_cur = t_cur / P;
        o_cur = t_cur % P;
        check("busy", busy, 1);
        check("done", done, (t_cur == t_done) ? 1 : 0);
        check("black", black, blk);
        if (o_cur < NPIX) check("screen_addr", screen_addr, o_cur);
        if (o_cur < NPIX + PL) check("memory_sel", memory_sel, (base + f_cur) % 128);
        if (o_cur >= PL && o_cur < PL + NPIX) begin
          n_cur = o_cur - PL;
          check("plot", plot, 1);
          check("x", x, n_cur % 160);
          check("y", y, n_cur / 160);
        end else begin
          check("plot", plot, 0);
        end
      end else begin
        check("busy", busy, 0);
        check("done", done, 0);
        check("plot", plot, 0);
        if (fresh) begin
          check("rst_screen_addr", screen_addr, 0);
          check("rst_memory_sel", memory_sel, 0);
          check("rst_black", black, 0);
          check("rst_x", x, 0);
          check("rst_y", y, 0);
        end
      end
      if (plot === 1'b1) plot_cnt++;
      if (done === 1'b1) done_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (jitter) begin
        image_sel   = 7'($urandom);
        frame_count = 3'($urandom);
        black_req   = 1'($urandom);
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at edge %0d", cyc);
    $fatal(1, "watchdog");
  end

  int img_c;

  initial begin
    step(3);
    resetn = 1'b1;
    step(100);
    check("idle_busy", busy, 0);
    check("idle_plots", plot_cnt, 0);

    // Run A: two frames from image 127, checks 7-bit wrap, inter-frame gap, single done.
    image_sel = 7'd127; frame_count = 3'd2; black_req = 1'b0; start = 1'b1;
    plot_cnt = 0; done_cnt = 0;
    step(1);                                   // t=0
    start = 1'b0; jitter = 1'b1;
    check("a_addr0", screen_addr, 0);
    check("a_busy0", busy, 1);
    step(2);                                   // t=2
    check("a_first_plot", plot, 1);
    check("a_first_xy", {x, 1'b0, y}, {8'd0, 1'b0, 7'd0});
    step(159);                                 // t=161
    check("a_x159", x, 159);
    check("a_y0", y, 0);
    step(1);                                   // t=162
    check("a_x_wrap", x, 0);
    check("a_y1", y, 1);
    step(19201 - 162);                         // t=19201
    check("a_last_plot", plot, 1);
    check("a_last_x", x, 159);
    check("a_last_y", y, 119);
    check("a_msel_f0", memory_sel, 127);
    step(1);                                   // t=19202
    check("a_gap_plot", plot, 0);
    check("a_gap_busy", busy, 1);
    step(4);                                   // t=19206
    check("a_f1_addr0", screen_addr, 0);
    check("a_f1_msel", memory_sel, 0);
    step(2);                                   // t=19208
    check("a_f1_first_plot", plot, 1);
    step(38408 - 19208);                       // t=38408
    check("a_done", done, 1);
    step(1);
    check("a_busy_low", busy, 0);
    check("a_plot_total", plot_cnt, 2 * NPIX);
    check("a_done_total", done_cnt, 1);
    jitter = 1'b0;

    // Run B: frame_count=0 with black, ignored mid-run start, start held through DONE.
    image_sel = 7'd100; frame_count = 3'd0; black_req = 1'b1; start = 1'b1;
    plot_cnt = 0; done_cnt = 0;
    step(1);                                   // t=0
    start = 1'b0; jitter = 1'b1;
    check("b_black", black, 1);
    step(500);                                 // t=500
    check("b_addr500", screen_addr, 500);
    start = 1'b1;
    step(1);                                   // t=501
    start = 1'b0;
    check("b_addr501", screen_addr, 501);
    step(19100 - 501);                         // t=19100
    jitter = 1'b0;
    img_c = int'($urandom_range(0, 127));
    image_sel = 7'(img_c); frame_count = 3'd1; black_req = 1'b0; start = 1'b1;
    step(102);                                 // t=19202
    check("b_done", done, 1);
    check("b_black_done", black, 1);
    check("b_msel", memory_sel, 100);
    step(1);                                   // idle cycle, start still high
    check("b_idle_busy", busy, 0);
    check("b_plot_total", plot_cnt, NPIX);
    check("b_done_total", done_cnt, 1);

    // Run C: restarted by the held start, then reset in the middle of the draw.
    step(1);                                   // t=0
    start = 1'b0; jitter = 1'b1;
    check("c_addr0", screen_addr, 0);
    check("c_msel", memory_sel, img_c);
    check("c_black", black, 0);
    step(10000);                               // t=10000
    check("c_addr10000", screen_addr, 10000);
    check("c_plot_x", x, 9998 % 160);
    check("c_plot_y", y, 9998 / 160);
    resetn = 1'b0;
    step(1);
    resetn = 1'b1;
    check("c_rst_busy", busy, 0);
    check("c_rst_plot", plot, 0);
    check("c_rst_addr", screen_addr, 0);
    plot_cnt = 0;
    step(50);
    jitter = 1'b0;
    check("c_no_plot_after_rst", plot_cnt, 0);
    check("c_idle_busy", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
